uart_rx_ctrl: RTL and testbench

//  Sequences the 16x-oversampled UART receiver core and buffers its output for the host.

---
 rtl/uart_rx_ctrl_pkg.sv | 19 +
 rtl/uart_rx_ctrl_if.sv | 11 +
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types for the UART receive controller: FSM states and the stored frame entry.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam int ENTRY_W = 10;

  // Bit 9 = framing error, bit 8 = parity error, bits 7:0 = received byte.
  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } entry_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side FWFT stream carrying received bytes and their error flags.
interface uart_rx_ctrl_if;
  logic [7:0] data;
  logic       perr;
  logic       ferr;
  logic       valid;
  logic       ready;

  modport master (output data, perr, ferr, valid, input ready);
  modport slave  (input data, perr, ferr, valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; a write is visible at dout the clock after push.
// Push while full is taken only alongside a pop; flush empties it and overrides push/pop.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Hold the head at zero while empty so the host never sees stale memory.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences the oversampled UART receiver core, turns its level outputs into one event per
// frame, queues {ferr,perr,data} for the host (1-clk FWFT latency) and keeps status counters.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 8,
  parameter int IDLE_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_en,
  input  logic                   rxd,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_err,
  input  logic                   rx_stop_err,
  output logic                   rx_core_rst,
  uart_rx_ctrl_if.master         m,
  input  logic                   flush,
  input  logic                   clr_status,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overrun,
  output logic                   brk,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       perr_cnt,
  output logic [CNT_W-1:0]       ferr_cnt
);
  localparam int             IW        = $clog2(IDLE_CYC + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_CYC - 1);

  state_t        state;
  state_t        state_nxt;
  logic          core_rst_nxt;
  logic          lvl_q;
  logic          perr_q;
  logic [IW-1:0] idle_cnt;
  logic          ev;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  entry_t        wentry;
  entry_t        hentry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The core may hold valid/stop_err for several clocks; only the rising edge counts.
  assign ev     = (state == ST_RUN) & (rx_valid | rx_stop_err) & ~lvl_q;
  // Parity error can lead rx_valid by a clock, so OR in last cycle's value.
  assign wentry = '{ferr: rx_stop_err, perr: (rx_parity_err | perr_q), data: rx_data};
  assign pop    = m.valid & m.ready;
  assign accept = ev & ~flush & (~fifo_full | pop);
  assign drop   = ev & ~flush & fifo_full & ~pop;

  always_comb begin
    state_nxt    = state;
    core_rst_nxt = (state != ST_RUN);
    unique case (state)
      ST_OFF: begin
        if (rx_en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!rx_en)                  state_nxt = ST_OFF;
        else if (ev && rx_stop_err) state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!rx_en)                          state_nxt = ST_OFF;
        else if (rxd && idle_cnt == IDLE_LAST) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_OFF;
      rx_core_rst <= 1'b1;
      lvl_q       <= 1'b0;
      perr_q      <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      rx_core_rst <= core_rst_nxt;
      lvl_q       <= rx_valid | rx_stop_err;
      perr_q      <= rx_parity_err;
      if (state == ST_RECOVER && rxd) idle_cnt <= idle_cnt + IW'(1);
      else                            idle_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_status) begin
      frame_cnt <= '0;
      perr_cnt  <= '0;
      ferr_cnt  <= '0;
      overrun   <= 1'b0;
      brk       <= 1'b0;
    end else begin
      if (accept) begin
        frame_cnt <= sat_inc(frame_cnt);
        if (wentry.perr) perr_cnt <= sat_inc(perr_cnt);
        if (wentry.ferr) ferr_cnt <= sat_inc(ferr_cnt);
        if (wentry.ferr && wentry.data == 8'h00) brk <= 1'b1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .flush (flush),
    .din   (wentry),
    .dout  (hentry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m.valid = ~fifo_empty;
  assign m.data  = hentry.data;
  assign m.perr  = hentry.perr;
  assign m.ferr  = hentry.ferr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame-level reference model feeds an expected queue.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int DEPTH    = 8;
  localparam int CNT_W    = 8;
  localparam int IDLE_CYC = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset, rx_en, rxd, rx_valid, rx_parity_err, rx_stop_err, flush, clr_status;
  logic [7:0] rx_data;
  logic       rx_core_rst, overrun, brk;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0] frame_cnt, perr_cnt, ferr_cnt;

  uart_rx_ctrl_if host();

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .IDLE_CYC(IDLE_CYC)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_en         (rx_en),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_parity_err (rx_parity_err),
    .rx_stop_err   (rx_stop_err),
    .rx_core_rst   (rx_core_rst),
    .m             (host),
    .flush         (flush),
    .clr_status    (clr_status),
    .fifo_count    (fifo_count),
    .overrun       (overrun),
    .brk           (brk),
    .frame_cnt     (frame_cnt),
    .perr_cnt      (perr_cnt),
    .ferr_cnt      (ferr_cnt)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [9:0] expq[$];
  bit         model_run  = 0;
  bit         rand_ready = 0;
  logic       base_ready = 0;
  int         m_frames = 0, m_perrs = 0, m_ferrs = 0;
  bit         m_overrun = 0, m_brk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every host pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (host.valid === 1'b1 && host.ready === 1'b1) begin
      if (expq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_entry: got %0h, expected no entry (scoreboard empty)",
                 {host.ferr, host.perr, host.data});
      end else begin
        chk("pop_entry", 32'({host.ferr, host.perr, host.data}), 32'(expq.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    flush      = 1'b0;
    clr_status = 1'b0;
    host.ready = rand_ready ? ($urandom_range(0, 3) != 0) : base_ready;
  endtask

  task automatic bump(inout int v);
    if (v < CNT_MAX) v++;
  endtask

  task automatic model_clear();
    m_frames = 0; m_perrs = 0; m_ferrs = 0; m_overrun = 0; m_brk = 0;
  endtask

  // One frame seen by the controller in the cycle its valid/stop_err first rises.
  task automatic model_event(input logic [9:0] e, input bit fl, input bit clr);
    bit pop_now, acc;
    if (model_run) begin
      pop_now = (host.ready === 1'b1) && (expq.size() > 0);
      acc     = !fl && (expq.size() < DEPTH || pop_now);
      if (acc) begin
        expq.push_back(e);
        bump(m_frames);
        if (e[8]) bump(m_perrs);
        if (e[9]) bump(m_ferrs);
        if (e[9] && e[7:0] == 8'h00) m_brk = 1;
      end else if (!fl) begin
        m_overrun = 1;
      end
      if (e[9]) model_run = 0;
    end
    if (fl)  expq.delete();
    if (clr) model_clear();
  endtask

  // pmode: 0 clean, 1 parity pulse one clock before valid, 2 parity together with valid.
  task automatic start_frame(input logic [7:0] d, input int pmode, input bit se,
                             input logic rdy, input bit fl, input bit clr);
    logic [9:0] e;
    if (pmode == 1) begin
      tick();
      rx_parity_err = 1'b1;
    end
    tick();
    rx_parity_err = (pmode == 2);
    if (se) rx_stop_err = 1'b1;
    else    rx_valid    = 1'b1;
    rx_data    = d;
    host.ready = rdy;
    flush      = fl;
    clr_status = clr;
    e = {se, (pmode != 0), d};
    model_event(e, fl, clr);
  endtask

  task automatic end_frame(input int hold);
    repeat (hold) tick();
    rx_valid = 1'b0; rx_stop_err = 1'b0; rx_parity_err = 1'b0;
    repeat (2) tick();
  endtask

  task automatic chk_status(input string tag);
    @(negedge clk);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), m_frames);
    chk({tag, "_perr_cnt"},  32'(perr_cnt),  m_perrs);
    chk({tag, "_ferr_cnt"},  32'(ferr_cnt),  m_ferrs);
    chk({tag, "_overrun"},   32'(overrun),   32'(m_overrun));
    chk({tag, "_brk"},       32'(brk),       32'(m_brk));
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    chk({tag, "_core_rst"}, 32'(rx_core_rst), 1);
    chk({tag, "_valid"},    32'(host.valid),  0);
    chk({tag, "_head"},     32'({host.ferr, host.perr, host.data}), 0);
    chk({tag, "_count"},    32'(fifo_count), 0);
    chk({tag, "_counters"}, 32'({frame_cnt, perr_cnt, ferr_cnt}), 0);
    chk({tag, "_sticky"},   32'({overrun, brk}), 0);
  endtask

  task automatic drain(input string tag);
    base_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    base_ready = 1'b0;
    tick();
    @(negedge clk);
    chk({tag, "_drain_count"}, 32'(fifo_count), 0);
    chk({tag, "_drain_left"},  32'(expq.size()), 0);
  endtask

  task automatic recover();
    rxd = 1'b1;
    repeat (IDLE_CYC + 4) tick();
    model_run = 1;
    @(negedge clk);
    chk("recover_core_rst", 32'(rx_core_rst), 0);
  endtask

  initial begin
    int glitch_k, ends_k, run;
    logic [7:0] d;
    bit se;
    reset = 1'b1; rx_en = 1'b0; rxd = 1'b1; rx_valid = 1'b0; rx_parity_err = 1'b0;
    rx_stop_err = 1'b0; rx_data = 8'h00; flush = 1'b0; clr_status = 1'b0; host.ready = 1'b0;
    repeat (2) tick();
    chk_reset("reset");
    tick();
    reset = 1'b0;
    rx_en = 1'b1;
    repeat (3) tick();
    model_run = 1;
    @(negedge clk);
    chk("run_core_rst", 32'(rx_core_rst), 0);

    // 1: valid held 3 clocks gives exactly one entry, visible one clock after the edge
    start_frame(8'hA5, 0, 0, 1'b0, 0, 0);
    @(negedge clk);
    chk("t1_valid_at_edge", 32'(host.valid), 0);
    tick();
    @(negedge clk);
    chk("t1_valid_next", 32'(host.valid), 1);
    chk("t1_count", 32'(fifo_count), 1);
    end_frame(2);
    @(negedge clk);
    chk("t1_count_after_hold", 32'(fifo_count), 1);
    chk_status("t1");
    drain("t1");

    // 2: parity error one clock ahead of valid
    start_frame(8'h3C, 1, 0, 1'b0, 0, 0);
    end_frame(2);
    chk_status("t2");
    drain("t2");

    // 3: break frame, then recovery with an rxd glitch
    glitch_k = 10;
    start_frame(8'h00, 0, 1, 1'b0, 0, 0);
    run = 0;
    ends_k = 0;
    for (int k = 1; k <= 30; k++) begin
      if (ends_k == 0) begin
        run = (k == glitch_k) ? 0 : run + 1;
        if (run == IDLE_CYC) ends_k = k;
      end
    end
    for (int k = 1; k <= 30; k++) begin
      tick();
      rxd = (k != glitch_k);
      if (k >= 3) rx_stop_err = 1'b0;
      @(negedge clk);
      chk($sformatf("t3_core_rst_k%0d", k), 32'(rx_core_rst),
          32'((k >= 2) && (k <= ends_k + 1)));
    end
    model_run = 1;
    chk_status("t3");
    drain("t3");

    // 4: overfill with host stalled, then pop+push while full
    tick();
    clr_status = 1'b1;
    model_clear();
    tick();
    for (int i = 0; i < DEPTH + 1; i++) begin
      start_frame(8'($urandom), 0, 0, 1'b0, 0, 0);
      end_frame(1);
    end
    @(negedge clk);
    chk("t4_count_full", 32'(fifo_count), DEPTH);
    chk_status("t4_full");
    start_frame(8'($urandom), 0, 0, 1'b1, 0, 0);
    end_frame(1);
    @(negedge clk);
    chk("t4_count_popush", 32'(fifo_count), DEPTH);
    chk_status("t4_popush");

    // 5: flush beats push; clr_status beats increment
    start_frame(8'h11, 0, 0, 1'b0, 1, 0);
    end_frame(1);
    @(negedge clk);
    chk("t5_flush_count", 32'(fifo_count), 0);
    chk("t5_flush_valid", 32'(host.valid), 0);
    start_frame(8'h22, 2, 0, 1'b0, 0, 1);
    end_frame(1);
    chk_status("t5_clr");
    chk("t5_clr_count", 32'(fifo_count), 1);

    // 6: receive disabled mid-frame keeps the queue
    tick();
    rx_en = 1'b0;
    model_run = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("t6_off_core_rst", 32'(rx_core_rst), 1);
    start_frame(8'h5A, 0, 0, 1'b0, 0, 0);
    end_frame(2);
    @(negedge clk);
    chk("t6_count_kept", 32'(fifo_count), 1);
    chk_status("t6");
    drain("t6");
    rx_en = 1'b1;
    repeat (3) tick();
    model_run = 1;

    // Randomized frames with random host backpressure
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      d  = 8'($urandom);
      se = ($urandom_range(0, 7) == 0);
      if (se && $urandom_range(0, 1) == 1) d = 8'h00;
      start_frame(d, int'($urandom_range(0, 2)), se, 1'($urandom_range(0, 1)), 0, 0);
      end_frame(int'($urandom_range(1, 3)));
      if (se) recover();
    end
    rand_ready = 0;
    chk_status("rand");
    drain("rand");

    // Synchronous reset in the middle of a frame
    start_frame(8'h81, 0, 0, 1'b0, 0, 0);
    end_frame(1);
    start_frame(8'h42, 0, 0, 1'b0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    expq.delete();
    model_clear();
    model_run = 0;
    chk_reset("midreset");
    reset = 1'b0;
    rx_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
